// File: rtl/mmio_uart_tx_pkg.sv
// Shared definitions for the memory-mapped UART transmitter: register map,
// STATUS bit positions, serializer state encoding and reset bit period.
package mmio_uart_tx_pkg;

  localparam logic [3:0] OFF_TXDATA = 4'h0;
  localparam logic [3:0] OFF_STATUS = 4'h4;
  localparam logic [3:0] OFF_CTRL   = 4'h8;
  localparam logic [3:0] OFF_DIV    = 4'hC;

  localparam int ST_FULL  = 0;
  localparam int ST_EMPTY = 1;
  localparam int ST_BUSY  = 2;
  localparam int ST_OVF   = 3;
  localparam int ST_COUNT = 7;

  localparam int DIV_RESET_DEF = 868;

  typedef enum logic [1:0] {S_IDLE, S_START, S_DATA, S_STOP} tx_state_e;

  function automatic logic [1:0] reg_idx(input logic [3:0] off);
    return off[3:2];
  endfunction

endpackage

// File: rtl/mmio_uart_tx_sync_fifo.sv
// Circular-buffer FIFO with a separate occupancy counter. The caller only
// raises push when there is room (or a pop frees a slot in the same cycle).
module mmio_uart_tx_sync_fifo #(
  parameter int W     = 8,
  parameter int DEPTH = 8
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push,
  input  logic                     pop,
  input  logic [W-1:0]             wdata,
  output logic [W-1:0]             rdata,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [W-1:0]  mem [DEPTH];
  logic [AW-1:0] wptr, rptr;

  always_ff @(posedge clk) begin
    if (push) mem[wptr] <= wdata;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wptr  <= '0;
      rptr  <= '0;
      count <= '0;
    end else begin
      if (push) wptr <= wptr + 1'b1;
      if (pop)  rptr <= rptr + 1'b1;
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  assign rdata = mem[rptr];
  assign full  = (count == CW'(DEPTH));
  assign empty = (count == '0);

endmodule

// File: rtl/mmio_uart_tx.sv
// MMIO 8N1 UART transmitter: register file, TX FIFO and bit serializer.
// Define MMIO_UART_TX_IRQ_EN to enable the CTRL register and the drained irq.
module mmio_uart_tx
  import mmio_uart_tx_pkg::*;
#(
  parameter int FIFO_DEPTH = 8,
  parameter int DIV_W      = 16,
  parameter int DIV_RESET  = DIV_RESET_DEF
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        sel,
  input  logic [3:0]  addr,
  input  logic [31:0] wdata,
  input  logic [3:0]  wenable,
  output logic [31:0] rdata,
  output logic        tx,
  output logic        irq
);
  localparam int CW = $clog2(FIFO_DEPTH) + 1;

  tx_state_e        state;
  logic [DIV_W-1:0] div, div_m1, cnt;
  logic [7:0]       shift;
  logic [2:0]       idx;
  logic             ovf, busy, ctl_bit;
  logic             wr_tx, wr_st, wr_ctl, wr_div, drop;
  logic             f_push, f_pop, f_full, f_empty;
  logic [7:0]       f_rdata;
  logic [CW-1:0]    f_count;
  logic [31:0]      status, rd_mux;

  assign wr_tx  = sel & wenable[0] & (addr[3:2] == reg_idx(OFF_TXDATA));
  assign wr_st  = sel & wenable[0] & (addr[3:2] == reg_idx(OFF_STATUS));
  assign wr_ctl = sel & wenable[0] & (addr[3:2] == reg_idx(OFF_CTRL));
  assign wr_div = sel & (addr[3:2] == reg_idx(OFF_DIV));

  // A full FIFO still accepts a byte when the serializer pops in the same cycle.
  assign f_pop  = (state == S_IDLE) & ~f_empty;
  assign f_push = wr_tx & (~f_full | f_pop);
  assign drop   = wr_tx & f_full & ~f_pop;
  assign busy   = (state != S_IDLE);
  assign div_m1 = (div == '0) ? '0 : div - 1'b1;

  mmio_uart_tx_sync_fifo #(.W(8), .DEPTH(FIFO_DEPTH)) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (f_push),
    .pop   (f_pop),
    .wdata (wdata[7:0]),
    .rdata (f_rdata),
    .full  (f_full),
    .empty (f_empty),
    .count (f_count)
  );

  always_comb begin
    status               = '0;
    status[ST_FULL]      = f_full;
    status[ST_EMPTY]     = f_empty;
    status[ST_BUSY]      = busy;
    status[ST_OVF]       = ovf;
    status[ST_COUNT+:CW] = f_count;
    rd_mux = '0;
    case (addr[3:2])
      reg_idx(OFF_STATUS): rd_mux = status;
      reg_idx(OFF_CTRL):   rd_mux[0] = ctl_bit;
      reg_idx(OFF_DIV):    rd_mux[DIV_W-1:0] = div;
      default:             rd_mux = '0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      ovf   <= 1'b0;
      div   <= DIV_W'(DIV_RESET);
      rdata <= '0;
    end else begin
      if (drop)                          ovf <= 1'b1;
      else if (wr_st && wdata[ST_OVF])   ovf <= 1'b0;
      if (wr_div && wenable[0]) div[7:0]       <= wdata[7:0];
      if (wr_div && wenable[1]) div[DIV_W-1:8] <= wdata[DIV_W-1:8];
      rdata <= sel ? rd_mux : '0;
    end
  end

`ifdef MMIO_UART_TX_IRQ_EN
  logic irq_en;
  assign ctl_bit = irq_en;
  // A push this cycle means the FIFO will not be empty next cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      irq_en <= 1'b0;
      irq    <= 1'b0;
    end else begin
      if (wr_ctl) irq_en <= wdata[0];
      irq <= irq_en & f_empty & ~busy & ~f_push;
    end
  end
  logic unused_bits;
  assign unused_bits = ^{addr[1:0], wdata[31:16], wenable[3:2]};
`else
  assign ctl_bit = 1'b0;
  assign irq     = 1'b0;
  logic unused_bits;
  assign unused_bits = ^{addr[1:0], wdata[31:16], wenable[3:2], wr_ctl};
`endif

  // Each bit lasts div_m1+1 cycles; div is re-read at every bit start.
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= S_IDLE;
      tx    <= 1'b1;
      cnt   <= '0;
      shift <= '0;
      idx   <= '0;
    end else begin
      case (state)
        S_IDLE: if (f_pop) begin
          shift <= f_rdata;
          cnt   <= div_m1;
          tx    <= 1'b0;
          state <= S_START;
        end
        S_START: if (cnt == '0) begin
          cnt   <= div_m1;
          idx   <= '0;
          tx    <= shift[0];
          state <= S_DATA;
        end else cnt <= cnt - 1'b1;
        S_DATA: if (cnt == '0) begin
          cnt <= div_m1;
          if (idx == 3'd7) begin
            tx    <= 1'b1;
            state <= S_STOP;
          end else begin
            idx   <= idx + 1'b1;
            shift <= {1'b0, shift[7:1]};
            tx    <= shift[1];
          end
        end else cnt <= cnt - 1'b1;
        S_STOP: if (cnt == '0) state <= S_IDLE;
                else cnt <= cnt - 1'b1;
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mmio_uart_tx.sv
// Directed bench for mmio_uart_tx: register table, exact frame timing,
// overflow, DIV=0, optional irq and mid-frame reset.
module tb_mmio_uart_tx;
  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        sel = 1'b0;
  logic [3:0]  addr = '0;
  logic [31:0] wdata = '0;
  logic [3:0]  wenable = '0;
  logic [31:0] rdata;
  logic        tx, irq;

  int n_chk = 0;
  int n_fail = 0;
  bit mon_en = 1'b1;
  int mon_div = 4;
  bit irq_hi = 1'b0;
  logic [7:0] rx_q[$];

  typedef struct {
    bit          is_rd;
    logic [3:0]  a;
    logic [31:0] d;
    logic [3:0]  we;
    logic [31:0] exp;
    string       name;
  } vec_t;
  vec_t tbl[$];

`ifdef MMIO_UART_TX_IRQ_EN
  localparam logic [31:0] CTRL_EXP = 32'h1;
`else
  localparam logic [31:0] CTRL_EXP = 32'h0;
`endif

  mmio_uart_tx #(.FIFO_DEPTH(8), .DIV_W(16), .DIV_RESET(868)) dut (
    .clk(clk), .rst(rst), .sel(sel), .addr(addr), .wdata(wdata),
    .wenable(wenable), .rdata(rdata), .tx(tx), .irq(irq)
  );

  always #5 clk = ~clk;
  always @(negedge clk) if (irq === 1'b1) irq_hi = 1'b1;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic wr(input logic [3:0] a, input logic [31:0] d, input logic [3:0] we);
    sel = 1'b1; addr = a; wdata = d; wenable = we;
    tick();
    sel = 1'b0; addr = '0; wdata = '0; wenable = '0;
  endtask

  task automatic rd(input logic [3:0] a, output logic [31:0] v);
    sel = 1'b1; addr = a; wenable = '0;
    tick();
    v = rdata;
    sel = 1'b0; addr = '0;
  endtask

  // Serial receiver: samples near the middle of each bit at the current mon_div.
  initial begin
    forever begin
      @(posedge clk); #2;
      if (mon_en && tx === 1'b0) begin
        logic [7:0] b;
        repeat (mon_div / 2) begin @(posedge clk); #2; end
        for (int i = 0; i < 8; i++) begin
          repeat (mon_div) begin @(posedge clk); #2; end
          b[i] = tx;
        end
        repeat (mon_div) begin @(posedge clk); #2; end
        chk("rx_stop_bit", {31'b0, tx}, 32'h1);
        rx_q.push_back(b);
      end
    end
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] v;
    logic [9:0]  frame;
    logic [7:0]  exp_b[9];
    int          low_seen;

    tbl.push_back('{1'b1, 4'h4, 32'h0,        4'b0000, 32'h2,    "rst_status"});
    tbl.push_back('{1'b1, 4'hC, 32'h0,        4'b0000, 32'd868,  "rst_div"});
    tbl.push_back('{1'b1, 4'h8, 32'h0,        4'b0000, 32'h0,    "rst_ctrl"});
    tbl.push_back('{1'b1, 4'h0, 32'h0,        4'b0000, 32'h0,    "txdata_read"});
    tbl.push_back('{1'b0, 4'hC, 32'h1234,     4'b0011, 32'h0,    ""});
    tbl.push_back('{1'b1, 4'hC, 32'h0,        4'b0000, 32'h1234, "div_rw"});
    tbl.push_back('{1'b0, 4'hC, 32'hFFFF,     4'b0001, 32'h0,    ""});
    tbl.push_back('{1'b1, 4'hC, 32'h0,        4'b0000, 32'h12FF, "div_lane0"});
    tbl.push_back('{1'b0, 4'hC, 32'h00AB5678, 4'b1100, 32'h0,    ""});
    tbl.push_back('{1'b1, 4'hC, 32'h0,        4'b0000, 32'h12FF, "div_lanes23"});
    tbl.push_back('{1'b1, 4'hE, 32'h0,        4'b0000, 32'h12FF, "addr_lsb_ignored"});
    tbl.push_back('{1'b0, 4'h8, 32'h1,        4'b0001, 32'h0,    ""});
    tbl.push_back('{1'b1, 4'h8, 32'h0,        4'b0000, CTRL_EXP, "ctrl_rw"});
    tbl.push_back('{1'b0, 4'h8, 32'h0,        4'b0001, 32'h0,    ""});
    tbl.push_back('{1'b0, 4'h4, 32'h8,        4'b0001, 32'h0,    ""});
    tbl.push_back('{1'b1, 4'h4, 32'h0,        4'b0000, 32'h2,    "status_idle"});

    repeat (3) tick();
    chk("rst_tx", {31'b0, tx}, 32'h1);
    chk("rst_rdata", rdata, 32'h0);
    chk("rst_irq", {31'b0, irq}, 32'h0);
    rst = 1'b0;
    tick();

    for (int i = 0; i < tbl.size(); i++) begin
      if (tbl[i].is_rd) begin
        rd(tbl[i].a, v);
        chk(tbl[i].name, v, tbl[i].exp);
      end else wr(tbl[i].a, tbl[i].d, tbl[i].we);
    end

    // 0x55 at DIV=4: exact per-cycle waveform plus STATUS busy/empty.
    wr(4'hC, 32'd4, 4'b0011);
    mon_div = 4;
    rx_q.delete();
    wr(4'h0, 32'h55, 4'b0001);
    sel = 1'b1; addr = 4'h4;
    chk("t55_gap", {31'b0, tx}, 32'h1);
    frame = {1'b1, 8'h55, 1'b0};
    for (int c = 0; c < 40; c++) begin
      tick();
      chk("t55_tx", {31'b0, tx}, {31'b0, frame[c/4]});
      if (c >= 1) begin
        chk("t55_busy", {31'b0, rdata[2]}, 32'h1);
        chk("t55_empty", {31'b0, rdata[1]}, 32'h1);
      end
    end
    tick();
    chk("t55_idle_tx", {31'b0, tx}, 32'h1);
    chk("t55_busy_last_stop", {31'b0, rdata[2]}, 32'h1);
    tick();
    chk("t55_busy_clear", {31'b0, rdata[2]}, 32'h0);
    chk("t55_empty_after", {31'b0, rdata[1]}, 32'h1);
    sel = 1'b0; addr = '0;
    tick();
    chk("rd_sel_low", rdata, 32'h0);
    repeat (2) tick();
    chk("t55_rx_count", rx_q.size(), 32'd1);
    if (rx_q.size() > 0) chk("t55_rx_byte", {24'b0, rx_q[0]}, 32'h55);

    // Burst of 10 at DIV=16: 9th fits after first pop, 10th overflows.
    wr(4'hC, 32'd16, 4'b0011);
    mon_div = 16;
    rx_q.delete();
    for (int i = 0; i < 8; i++) wr(4'h0, 32'(i), 4'b0001);
    wr(4'h0, 32'hFF, 4'b0001);
    wr(4'h0, 32'hAA, 4'b0001);
    rd(4'h4, v);
    chk("burst_status_ovf", v, 32'h40D);
    wr(4'h4, 32'h8, 4'b0001);
    rd(4'h4, v);
    chk("burst_ovf_cleared", v, 32'h405);
    for (int t = 0; t < 4000 && rx_q.size() < 9; t++) tick();
    chk("burst_rx_count", rx_q.size(), 32'd9);
    for (int i = 0; i < 8; i++) exp_b[i] = 8'(i);
    exp_b[8] = 8'hFF;
    for (int i = 0; i < 9 && i < rx_q.size(); i++)
      chk("burst_rx_byte", {24'b0, rx_q[i]}, {24'b0, exp_b[i]});
    repeat (20) tick();
    rd(4'h4, v);
    chk("burst_drained", v, 32'h2);

    // DIV=0 behaves as 1: 10-cycle frame.
    wr(4'hC, 32'd0, 4'b0011);
    mon_div = 1;
    rx_q.delete();
    wr(4'h0, 32'hA5, 4'b0001);
    chk("a5_gap", {31'b0, tx}, 32'h1);
    frame = {1'b1, 8'hA5, 1'b0};
    for (int c = 0; c < 10; c++) begin
      tick();
      chk("a5_tx", {31'b0, tx}, {31'b0, frame[c]});
    end
    tick();
    chk("a5_after", {31'b0, tx}, 32'h1);
    repeat (3) tick();
    chk("a5_rx_count", rx_q.size(), 32'd1);
    if (rx_q.size() > 0) chk("a5_rx_byte", {24'b0, rx_q[0]}, 32'hA5);

`ifdef MMIO_UART_TX_IRQ_EN
    wr(4'hC, 32'd2, 4'b0011);
    mon_div = 2;
    wr(4'h8, 32'h1, 4'b0001);
    tick();
    chk("irq_idle_high", {31'b0, irq}, 32'h1);
    wr(4'h0, 32'h3C, 4'b0001);
    chk("irq_drop_on_push", {31'b0, irq}, 32'h0);
    repeat (21) tick();
    chk("irq_low_first_idle", {31'b0, irq}, 32'h0);
    tick();
    chk("irq_rise", {31'b0, irq}, 32'h1);
    wr(4'h8, 32'h0, 4'b0001);
    repeat (4) tick();
`endif

    // Reset during DATA bit 3 with two bytes still queued.
    mon_en = 1'b0;
    wr(4'hC, 32'd8, 4'b0011);
    wr(4'h0, 32'hF7, 4'b0001);
    wr(4'h0, 32'h11, 4'b0001);
    wr(4'h0, 32'h22, 4'b0001);
    rd(4'h4, v);
    chk("queued_status", v, 32'h104);
    repeat (33) tick();
    chk("mid_bit3_tx", {31'b0, tx}, 32'h0);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("abort_tx", {31'b0, tx}, 32'h1);
    chk("abort_rdata", rdata, 32'h0);
    rd(4'h4, v);
    chk("abort_status", v, 32'h2);
    rd(4'hC, v);
    chk("abort_div", v, 32'd868);
    low_seen = 0;
    for (int t = 0; t < 300; t++) begin
      tick();
      if (tx !== 1'b1) low_seen++;
    end
    chk("abort_no_frames", low_seen, 32'd0);

`ifndef MMIO_UART_TX_IRQ_EN
    chk("irq_never_high", {31'b0, irq_hi}, 32'h0);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/mmio_uart_tx.md
Name: mmio_uart_tx

Overview:
- Memory-mapped UART transmitter on the CPU data port (data_addr/data_wdata/data_wenable/data_rdata), downstream of pipelined_cpu, in parallel with the data RAM.
- Firmware writes bytes into a TX FIFO. A serializer shifts them out as 8N1 frames on a single output pin.
- An optional interrupt drives the CPU irq input.
- Replaces "mem write" console prints in firmware bring-up with a real serial console.

Parameters:
- FIFO_DEPTH, 8, TX FIFO entries; power of two, >= 2.
- DIV_W, 16, divisor register width.
- DIV_RESET, 868, reset bit period in clk cycles (100 MHz / 115200).

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  synchronous, active-high reset.
- sel  in  1  chip select from external address decode; this block's 16-byte window is addressed this cycle.
- addr  in  4  byte offset within the window; bits [1:0] ignored.
- wdata  in  32  write data.
- wenable  in  4  byte-lane write enables, same semantics as the data port.
- rdata  out  32  read data, registered.
- tx  out  1  serial output, idle high.
- irq  out  1  interrupt request, level.

Behaviour:
- Register map (word offsets):
  - 0x0 TXDATA: write lane 0 pushes wdata[7:0]; reads 0.
  - 0x4 STATUS (read): bit0 full, bit1 empty, bit2 busy (serializer not IDLE), bit3 overflow (sticky), bits[7+:4] FIFO count. Writing 1 to bit3 (lane 0) clears overflow.
  - 0x8 CTRL: bit0 irq_en (R/W, lane 0).
  - 0xC DIV: bits[DIV_W-1:0] bit period (R/W, lanes 0–1).
- Write cycle: sel & |wenable. Read data is registered: rdata reflects the address sampled at cycle N during cycle N+1, matching RAM read timing. rdata = 0 when sel was low.
- Push:
  - Push occurs when a TXDATA write arrives and the FIFO is not full.
  - If the FIFO is full and no pop occurs in the same cycle, the byte is dropped and overflow is set.
  - Full with push and pop in the same cycle: push accepted, count unchanged.
- FIFO: circular buffer, pointers wrap modulo FIFO_DEPTH. Count is held as a separate clog2(FIFO_DEPTH)+1-bit counter.
- Serializer FSM states: IDLE, START, DATA, STOP.
  - IDLE: if FIFO non-empty, pop into the shift register, load baud counter, go to START. Otherwise stay.
  - START: tx=0 for one bit period, then DATA with bit index 0.
  - DATA: tx=shift[0], LSB first. At each period end, shift right and increment index. After index 7, go to STOP.
  - STOP: tx=1 for one bit period, then IDLE. A pending byte is popped on the IDLE cycle, so there is 1 idle cycle between frames.
- Bit period:
  - Baud counter loads DIV-1 at each bit start and decrements; the bit ends at 0.
  - DIV value 0 is treated as 1.
  - A DIV write mid-frame takes effect at the next bit boundary.
- Latency: TXDATA write in cycle N with FIFO empty and FSM IDLE gives pop at edge N+1, and tx falls at the start of cycle N+2. Frame length = 10*DIV cycles.
- Reset: tx=1, rdata=0, irq=0, FSM=IDLE, FIFO empty, overflow=0, irq_en=0, DIV=DIV_RESET.
  - Reset mid-frame aborts immediately and drives tx=1 the next cycle.
  - FIFO contents are discarded.

Optional Feature:
- Macro: MMIO_UART_TX_IRQ_EN.
- Defined: irq = irq_en & empty & ~busy, i.e. TX drained. The flag is registered, so irq asserts 1 cycle after STOP→IDLE with an empty FIFO.
- Undefined: irq tied 0; CTRL reads 0 and its writes are ignored.

Decomposition:
- Shared package holds:
  - register offsets (TXDATA/STATUS/CTRL/DIV);
  - STATUS bit indices;
  - FSM state enum (2-bit);
  - DIV_RESET default.
- One natural sub-module: sync_fifo (width 8, depth FIFO_DEPTH; push/pop/full/empty/count). Serializer and register file stay in the top.

Test Plan:
- Reset, DIV=4, write 0x55 to TXDATA → tx low 4 cycles starting at cycle N+2, then 1,0,1,0,1,0,1,0 (4 cycles each), stop high 4 cycles. busy=1 throughout; empty=1 after the pop.
- Burst 8 bytes 0x00..0x07 back-to-back, then a 9th (0xFF) while the first is still in START → 0xFF accepted, because one entry was already popped. A 10th write → dropped, STATUS bit3=1. Write 0x8 to STATUS → bit3 clears. Decoded frames are 0x00..0x07,0xFF.
- DIV=0 write → bit period 1 cycle; byte 0xA5 → frame of 10 cycles, LSB-first 1,0,1,0,0,1,0,1.
- Read STATUS at cycle N → rdata valid in cycle N+1 with count field matching FIFO occupancy; read with sel low → 0.
- With MMIO_UART_TX_IRQ_EN: CTRL=1, send one byte → irq rises 1 cycle after the stop bit ends. Writing TXDATA → irq drops the next cycle. Without the macro → irq always 0.
- Assert rst during DATA bit 3 with 2 bytes queued → next cycle tx=1, empty=1, busy=0, DIV=868; no further frames.
